// File: rtl/dffram_pkg.sv
// dffram_pkg: shared widths, state encoding and address map for the DFF RAM byte sequencer
package dffram_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int NIBBLE_W = 4;
  localparam int LAST_ADDR = 25;
  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, VF_LO, VF_HI, RESP} state_t;
  function automatic logic is_mapped(input logic [ADDR_W-1:0] addr);
    return addr <= ADDR_W'(LAST_ADDR);
  endfunction
endpackage

// File: rtl/dffram_byte_sequencer_if.sv
// dffram_byte_sequencer_if: byte request/response handshake between a requester and the sequencer
interface dffram_byte_sequencer_if;
  import dffram_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  modport master(output req_valid, req_we, req_addr, req_wdata, rsp_ready,
                 input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input req_valid, req_we, req_addr, req_wdata, rsp_ready,
                output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dffram_byte_sequencer.sv
// dffram_byte_sequencer: splits byte requests into nibble RAM accesses; DFFRAM_SEQ_READBACK_EN adds write readback verify
module dffram_byte_sequencer
  import dffram_pkg::*;
#(
  parameter int RD_LAT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  dffram_byte_sequencer_if.slave bus,
  output logic [ADDR_W-1:0]   ram_addr_a,
  output logic [NIBBLE_W-1:0] ram_wdata_a,
  output logic                ram_lohi_a,
  output logic                ram_w_en,
  output logic [ADDR_W-1:0]   ram_addr_b,
  output logic                ram_lohi_b,
  input  logic [NIBBLE_W-1:0] ram_rdata_b
);
  state_t state, nxt;
  logic live, cnt, last, rd, wr, accept;
  logic err;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data, rdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 1'b0;
      live <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= rd && !last;
      live <= 1'b1;
    end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (accept) nxt = !is_mapped(bus.req_addr) ? RESP : bus.req_we ? WR_LO : RD_LO;
      WR_LO: nxt = WR_HI;
`ifdef DFFRAM_SEQ_READBACK_EN
      WR_HI: nxt = VF_LO;
      VF_LO: if (last) nxt = VF_HI;
      VF_HI: if (last) nxt = RESP;
`else
      WR_HI: nxt = RESP;
`endif
      RD_LO: if (last) nxt = RD_HI;
      RD_HI: if (last) nxt = RESP;
      RESP:  if (bus.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    wr = state inside {WR_LO, WR_HI};
    rd = state inside {RD_LO, RD_HI, VF_LO, VF_HI};
    last = cnt == 1'(RD_LAT);
    bus.req_ready = live && state == IDLE;
    accept = bus.req_valid && bus.req_ready;
    bus.rsp_valid = state == RESP;
    bus.rsp_rdata = bus.rsp_valid ? rdata : '0;
    bus.rsp_err = bus.rsp_valid && err;
    ram_w_en = wr;
    ram_lohi_a = state == WR_LO;
    ram_addr_a = wr ? addr : '0;
    ram_wdata_a = state == WR_LO ? data[NIBBLE_W-1:0] : state == WR_HI ? data[DATA_W-1:NIBBLE_W] : '0;
    ram_addr_b = rd ? addr : '0;
    ram_lohi_b = state inside {RD_HI, VF_HI};
  end

  // Port B data is sampled only on the final cycle of each read state so a buffered RAM has settled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      data <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else if (accept) begin
      addr <= bus.req_addr;
      data <= bus.req_wdata;
      rdata <= '0;
      err <= !is_mapped(bus.req_addr);
    end else if (rd && last) begin
      if (ram_lohi_b) rdata[DATA_W-1:NIBBLE_W] <= ram_rdata_b;
      else rdata[NIBBLE_W-1:0] <= ram_rdata_b;
`ifdef DFFRAM_SEQ_READBACK_EN
      if (state == VF_HI) err <= {ram_rdata_b, rdata[NIBBLE_W-1:0]} != data;
`endif
    end
endmodule
